seg_display_arbiter: RTL and testbench

//  Shares one two-digit hex display (HEX1:HEX0) between N_REQ requesters using round-robin arbitration.

---
 rtl/seg_ctrl_pkg.sv | 26 ++
 rtl/seg_rr_pick.sv | 54 +++++
 rtl/seg_display_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seg_ctrl_pkg
//   Shared definitions for the display-sharing blocks.
//   - seg_state_e   : controller state encoding (IDLE / SHOW / GAP)
//   - SEG_OFF       : all-segments-off pattern for the downstream blanking mux
//   - seg_cnt_width : width of a down-counter that must hold dwell-1 and gap-1
// ----------------------------------------------------------------------------
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } seg_state_e;

    // Active-low segments: every segment dark.
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Width that holds max(dwell, blank) without truncation.
    function automatic int seg_cnt_width(input int dwell, input int blank);
        int biggest;
        biggest = (dwell > blank) ? dwell : blank;
        return $clog2(biggest + 1);
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// ----------------------------------------------------------------------------
// seg_rr_pick
//   Combinational round-robin picker: returns the first set request at or
//   after rrPtr, wrapping from N_REQ-1 back to 0 (works for any N_REQ >= 2,
//   power of two or not).
// Ports
//   req      in  N_REQ  request vector
//   rrPtr    in  ID_W   highest-priority index this round (must be < N_REQ)
//   anyReq   out 1      at least one request is set
//   winnerId out ID_W   chosen index (0 when anyReq is low)
// ----------------------------------------------------------------------------
module seg_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rrPtr,
    output logic             anyReq,
    output logic [ID_W-1:0]  winnerId
);

    // One extra bit so base+offset never overflows before the wrap.
    localparam int SUM_W = ID_W + 1;

    // (base + off) mod N_REQ; base and off are both < N_REQ so one subtract suffices.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + SUM_W'(off);
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest set request is written last and wins.
    always_comb begin
        logic [ID_W-1:0] idx_s;
        anyReq   = 1'b0;
        winnerId = '0;
        idx_s    = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx_s = wrap_add(rrPtr, off);
            if (req[idx_s]) begin
                anyReq   = 1'b1;
                winnerId = idx_s;
            end else begin
                anyReq   = anyReq;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// ----------------------------------------------------------------------------
// seg_display_arbiter
//   Shares one two-digit hex display between N_REQ requesters. The winner of a
//   round-robin pick is shown for DWELL_CYCLES clocks (longer while hold is
//   high), then the display goes dark for BLANK_CYCLES clocks before the next
//   pick. An owner that drops its request leaves immediately. All outputs are
//   registered.
// Ports
//   clk        in  1        system clock, rising edge
//   rst_n      in  1        asynchronous active-low reset
//   req        in  N_REQ    per-requester display request (level)
//   reqData    in  8*N_REQ  byte i is requester i's value
//   hold       in  1        keep the current owner past its dwell time
//   grant      out N_REQ    one-hot current owner, zero when none
//   activeId   out ID_W     current owner, or last owner when grant is zero
//   dispValue  out 8        value for the hex decoder
//   dispBlank  out 1        1 = display dark
// ----------------------------------------------------------------------------
module seg_display_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   reqData,
    input  logic                 hold,
    output logic [N_REQ-1:0]     grant,
    output logic [$clog2(N_REQ)-1:0] activeId,
    output logic [7:0]           dispValue,
    output logic                 dispBlank
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = seg_cnt_width(DWELL_CYCLES, BLANK_CYCLES);

    localparam bit               HAS_GAP    = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]  ID_ONE     = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [N_REQ-1:0] GRANT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    seg_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]         active_id_q, active_id_d;
    logic [7:0]              disp_value_q, disp_value_d;
    logic                    disp_blank_q, disp_blank_d;

    logic [N_REQ-1:0][7:0]   req_bytes_s;
    logic [ID_W-1:0]         owner_next_s;
    logic [ID_W-1:0]         pick_ptr_s;
    logic [ID_W-1:0]         winner_s;
    logic                    any_req_s;
    logic                    owner_drop_s;
    logic                    dwell_done_s;
    logic                    take_s;

    assign req_bytes_s  = reqData;
    assign owner_drop_s = ~req[active_id_q];
    assign dwell_done_s = (cnt_q == '0) && ~hold;

    // Index after the current owner, wrapping at N_REQ.
    assign owner_next_s = (active_id_q == LAST_ID) ? '0 : active_id_q + ID_ONE;

    // While showing, a gapless hand-over must already see the advanced pointer.
    assign pick_ptr_s = (state_q == ST_SHOW) ? owner_next_s : rr_ptr_q;

    seg_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req      (req),
        .rrPtr    (pick_ptr_s),
        .anyReq   (any_req_s),
        .winnerId (winner_s)
    );

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            active_id_q  <= '0;
            disp_value_q <= 8'h00;
            disp_blank_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            active_id_q  <= active_id_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
        end
    end

    // Next state, counter and round-robin pointer; take_s flags a fresh grant.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        take_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_SHOW;
                    cnt_d   = DWELL_LOAD;
                    take_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW: begin
                // A dropped request overrides hold; hold only stretches an expired dwell.
                if (owner_drop_s || dwell_done_s) begin
                    rr_ptr_d = owner_next_s;
                    if (HAS_GAP) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (any_req_s) begin
                        state_d = ST_SHOW;
                        cnt_d   = DWELL_LOAD;
                        take_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (any_req_s) begin
                        state_d = ST_SHOW;
                        cnt_d   = DWELL_LOAD;
                        take_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_d      = grant_q;
        active_id_d  = active_id_q;
        disp_value_d = disp_value_q;
        disp_blank_d = disp_blank_q;
        if (take_s) begin
            grant_d      = GRANT_ONE << winner_s;
            active_id_d  = winner_s;
            disp_value_d = req_bytes_s[winner_s];
            disp_blank_d = 1'b0;
        end else if (state_d == ST_SHOW) begin
            // Live tracking of the owner's byte, one clock behind reqData.
            disp_value_d = req_bytes_s[active_id_q];
        end else begin
            // Leaving or outside SHOW: dark display, value frozen, last owner kept.
            grant_d      = '0;
            disp_blank_d = 1'b1;
        end
    end

    assign grant     = grant_q;
    assign activeId  = active_id_q;
    assign dispValue = disp_value_q;
    assign dispBlank = disp_blank_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: two instances share one stimulus, one with a
// 2-clock gap and one with no gap. A behavioural model predicts both every clock.
module tb_seg_display_arbiter;

    localparam int NR = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic        hold;

    logic [3:0]  grant_a, grant_b;
    logic [1:0]  id_a, id_b;
    logic [7:0]  val_a, val_b;
    logic        blank_a, blank_b;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_arbiter #(.N_REQ(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .reqData(reqData), .hold(hold),
        .grant(grant_a), .activeId(id_a), .dispValue(val_a), .dispBlank(blank_a));

    seg_display_arbiter #(.N_REQ(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .reqData(reqData), .hold(hold),
        .grant(grant_b), .activeId(id_b), .dispValue(val_b), .dispBlank(blank_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 showing, 2 dark gap. elapsed counts edges spent in the phase.
    int         m_phase[2];
    int         m_elapsed[2];
    int         m_owner[2];
    int         m_ptr[2];
    logic [3:0] e_grant[2];
    logic [1:0] e_id[2];
    logic [7:0] e_val[2];
    logic       e_blank[2];

    function automatic int pick(input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        logic [31:0] d;
        d = reqData;
        return d[i*8 +: 8];
    endfunction

    task automatic m_reset(input int m);
        m_phase[m] = 0; m_elapsed[m] = 0; m_owner[m] = 0; m_ptr[m] = 0;
        e_grant[m] = 4'b0000; e_id[m] = 2'd0; e_val[m] = 8'h00; e_blank[m] = 1'b1;
    endtask

    task automatic m_start(input int m, input int w);
        m_phase[m] = 1; m_elapsed[m] = 0; m_owner[m] = w;
        e_grant[m] = 4'b0001 << w; e_id[m] = 2'(w); e_val[m] = byte_of(w); e_blank[m] = 1'b0;
    endtask

    task automatic m_step(input int m, input int dwell, input int gap);
        int w;
        case (m_phase[m])
            0: begin
                w = pick(m_ptr[m]);
                if (w >= 0) m_start(m, w);
            end
            1: begin
                m_elapsed[m]++;
                if (!req[m_owner[m]] || (m_elapsed[m] >= dwell && !hold)) begin
                    m_ptr[m] = (m_owner[m] + 1) % NR;
                    e_grant[m] = 4'b0000; e_blank[m] = 1'b1;
                    if (gap > 0) begin
                        m_phase[m] = 2; m_elapsed[m] = 0;
                    end else begin
                        w = pick(m_ptr[m]);
                        if (w >= 0) m_start(m, w); else m_phase[m] = 0;
                    end
                end else begin
                    e_val[m] = byte_of(m_owner[m]);
                end
            end
            2: begin
                m_elapsed[m]++;
                if (m_elapsed[m] >= gap) begin
                    w = pick(m_ptr[m]);
                    if (w >= 0) m_start(m, w); else m_phase[m] = 0;
                end
            end
            default: m_phase[m] = 0;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset(0); m_reset(1);
        end else begin
            m_step(0, 4, 2);
            m_step(1, 4, 0);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a_grant", 32'(grant_a), 32'(e_grant[0]));
        chk("a_id",    32'(id_a),    32'(e_id[0]));
        chk("a_value", 32'(val_a),   32'(e_val[0]));
        chk("a_blank", 32'(blank_a), 32'(e_blank[0]));
        chk("b_grant", 32'(grant_b), 32'(e_grant[1]));
        chk("b_id",    32'(id_b),    32'(e_id[1]));
        chk("b_value", 32'(val_b),   32'(e_val[1]));
        chk("b_blank", 32'(blank_b), 32'(e_blank[1]));
    end

    // Grant-order recorders: log owner whenever a new one-hot grant appears.
    int q_a[$];
    int q_b[$];
    logic [3:0] prev_a = 4'b0000, prev_b = 4'b0000;
    always @(negedge clk) begin
        if (grant_a != 4'b0000 && grant_a != prev_a) q_a.push_back(int'(id_a));
        if (grant_b != 4'b0000 && grant_b != prev_b) q_b.push_back(int'(id_b));
        prev_a = grant_a;
        prev_b = grant_b;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk_reset_vals(input string nm);
        chk({nm, "_grant_a"}, 32'(grant_a), 32'h0);
        chk({nm, "_id_a"},    32'(id_a),    32'h0);
        chk({nm, "_val_a"},   32'(val_a),   32'h00);
        chk({nm, "_blank_a"}, 32'(blank_a), 32'h1);
        chk({nm, "_grant_b"}, 32'(grant_b), 32'h0);
        chk({nm, "_blank_b"}, 32'(blank_b), 32'h1);
    endtask

    // Assert reset asynchronously just after an edge, check at once, release mid-cycle.
    task automatic do_reset(input string nm);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(nm);
        req = 4'b0000; hold = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input int budget, input string nm);
        int n;
        n = 0;
        while (grant_a !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (grant_a !== exp) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout, grant got %b expected %b", nm, grant_a, exp);
        end
    endtask

    task automatic wait_any(output logic [3:0] g, input int budget, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (grant_a === 4'b0000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        g = grant_a;
        if (grant_a === 4'b0000) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout, grant got 0 expected nonzero", nm);
        end
    endtask

    logic [3:0] seq2_g[7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    int         ord3[5]   = '{0, 1, 2, 3, 0};
    int         ord5[3]   = '{0, 2, 0};

    initial begin
        logic [3:0] g;
        int         blank_seen;
        bit         started;

        rst_n = 1'b0; req = 4'b0000; reqData = 32'h0; hold = 1'b0;

        // 1: idle after reset, release mid-cycle, stays dark for 20 clocks
        repeat (3) @(negedge clk);
        chk_reset_vals("t1_inreset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t1_blank", 32'(blank_a), 32'h1);
            chk("t1_grant", 32'(grant_a), 32'h0);
            chk("t1_value", 32'(val_a),   32'h00);
        end

        // 2: sole requester 0 -> 4 shown, 2 dark, re-granted
        do_reset("t2_rst");
        @(negedge clk);
        req = 4'b0001; reqData = 32'h0000003C;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t2_grant_seq", 32'(grant_a), 32'(seq2_g[k]));
            chk("t2_value",     32'(val_a),   32'h3C);
            chk("t2_blank",     32'(blank_a), (seq2_g[k] == 4'b0000) ? 32'h1 : 32'h0);
        end

        // 3: all four requesting -> order 0,1,2,3,0
        do_reset("t3_rst");
        q_a.delete();
        @(negedge clk);
        req = 4'b1111; reqData = 32'h43322110;
        repeat (32) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t3_rr_order", (k < q_a.size()) ? 32'(q_a[k]) : 32'hFF, 32'(ord3[k]));
        end

        // 4: hold keeps owner 1 past its dwell; value tracks reqData; dropping req exits
        do_reset("t4_rst");
        @(negedge clk);
        req = 4'b0010; reqData = 32'h00005500;
        wait_grant(4'b0010, 10, "t4_first_grant");
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_grant", 32'(grant_a), 32'h2);
            if (i > 0) chk("t4_track", 32'(val_a), 32'(8'h60 + 8'(i - 1)));
            reqData[15:8] = 8'h60 + 8'(i);
        end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("t4_drop_grant", 32'(grant_a), 32'h0);
        chk("t4_drop_blank", 32'(blank_a), 32'h1);
        chk("t4_drop_value", 32'(val_a),   32'h69);
        chk("t4_drop_id",    32'(id_a),    32'h1);
        hold = 1'b0;

        // 5: no-gap instance alternates 0,2,0 and never blanks between owners
        do_reset("t5_rst");
        q_b.delete();
        @(negedge clk);
        req = 4'b0101; reqData = 32'h00330011;
        blank_seen = 0; started = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (grant_b != 4'b0000) started = 1'b1;
            if (started && blank_b) blank_seen++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("t5_order", (k < q_b.size()) ? 32'(q_b[k]) : 32'hFF, 32'(ord5[k]));
        end
        chk("t5_no_blank", 32'(blank_seen), 32'h0);

        // 6: reset mid-GAP and mid-SHOW; arbitration restarts from index 0
        do_reset("t6_rst0");
        @(negedge clk);
        req = 4'b1111; reqData = 32'h43322110;
        wait_grant(4'b0001, 10, "t6_g0");
        wait_grant(4'b0000, 10, "t6_gap");
        do_reset("t6_midgap");
        req = 4'b1111;
        wait_any(g, 10, "t6_after_gap");
        chk("t6_restart_gap", 32'(g), 32'h1);
        wait_grant(4'b0010, 20, "t6_g1");
        do_reset("t6_midshow");
        req = 4'b1111;
        wait_any(g, 10, "t6_after_show");
        chk("t6_restart_show", 32'(g), 32'h1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
